decode_stage_pipe: RTL and testbench

//  Registered, handshaked MIPS instruction-decode stage (the ID/EX pipeline register) for the pipelined core.

---
 rtl/decode_stage_pipe.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
// -----------------------------------------------------------------------------
// decode_stage_pipe
//
// Instruction-decode stage of the pipelined MIPS core, implemented as the
// ID/EX pipeline register with valid/ready handshakes on both sides.
//
// Decoded instructions:
//   R-type add/sub/and/or/nor/slt/jr, addi, slti, lw, lb, sw, beq, bgtz, j, jal.
//   Anything else becomes a NOP with every enable cleared.
//
// Hazard handling:
//   A load-use interlock inserts one bubble when the instruction in IF reads
//   the destination of a load that left this stage on the previous edge.
//   flush kills the held instruction and any pending load state.
//   stall_cnt counts bubble cycles and saturates at all-ones.
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   flush      kill held instruction and hazard state (taken branch/jump)
//   in_valid   IF presents in_instr / in_pc
//   in_ready   stage accepts this cycle (combinational)
//   in_instr   instruction word, bits [31:0] decoded
//   in_pc      PC of in_instr
//   out_valid  registered decode fields are valid
//   out_ready  EX consumes the fields this cycle
//   out_pc     registered PC
//   op         ALU op (AND=0000 OR=0001 ADD=0010 SUB=0110 SLT=0111 NOR=1100 NOP=1111)
//   ssel       1 = ALU source B is rs2, 0 = imm
//   wbsel      writeback source: 0 = ALU, 1 = dmem, 2 = pc+4
//   we_regfile register-file write enable
//   we_dmem    data-memory write enable
//   mem_byte   1 = byte access (lb)
//   jump_type  NOP=000 BEQ=001 JAL=010 JR=011 J=100 BGTZ=101
//   jump_addr  instr[25:0]
//   imm        instr[15:0] sign-extended
//   rs1_id     instr[25:21]
//   rs2_id     instr[20:16]
//   rdst_id    destination register (rd, rt, or 31 for jal)
//   stall_cnt  number of load-use bubble cycles, saturating
// -----------------------------------------------------------------------------
module decode_stage_pipe #(
    parameter int DWIDTH         = 32,
    parameter int CNT_WIDTH      = 16,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DWIDTH-1:0]    in_instr,
    input  logic [DWIDTH-1:0]    in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DWIDTH-1:0]    out_pc,
    output logic [3:0]           op,
    output logic                 ssel,
    output logic [1:0]           wbsel,
    output logic                 we_regfile,
    output logic                 we_dmem,
    output logic                 mem_byte,
    output logic [2:0]           jump_type,
    output logic [25:0]          jump_addr,
    output logic [DWIDTH-1:0]    imm,
    output logic [4:0]           rs1_id,
    output logic [4:0]           rs2_id,
    output logic [4:0]           rdst_id,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    // Primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BGTZ  = 6'h07;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_LB    = 6'h20;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operations
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    // Jump types
    localparam logic [2:0] JT_NOP  = 3'b000;
    localparam logic [2:0] JT_BEQ  = 3'b001;
    localparam logic [2:0] JT_JAL  = 3'b010;
    localparam logic [2:0] JT_JR   = 3'b011;
    localparam logic [2:0] JT_J    = 3'b100;
    localparam logic [2:0] JT_BGTZ = 3'b101;

    // Writeback sources
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Control fields produced by the decoder; use_rs/use_rt/is_load feed the
    // interlock and are not exported.
    typedef struct packed {
        logic [3:0] op;
        logic       ssel;
        logic [1:0] wbsel;
        logic       we_regfile;
        logic       we_dmem;
        logic       mem_byte;
        logic [2:0] jump_type;
        logic [4:0] rdst_id;
        logic       use_rs;
        logic       use_rt;
        logic       is_load;
    } dec_t;

    // Pure combinational decode of one 32-bit instruction word.
    function automatic dec_t decode_fn(input logic [31:0] instr);
        dec_t d;
        d            = '0;
        d.op         = ALU_NOP;
        d.wbsel      = WB_ALU;
        d.jump_type  = JT_NOP;
        d.rdst_id    = 5'd0;
        d.use_rs     = 1'b1;
        case (instr[31:26])
            OPC_RTYPE: begin
                d.ssel    = 1'b1;
                d.use_rt  = 1'b1;
                d.rdst_id = instr[15:11];
                case (instr[5:0])
                    FN_ADD: begin d.op = ALU_ADD; d.we_regfile = 1'b1; end
                    FN_SUB: begin d.op = ALU_SUB; d.we_regfile = 1'b1; end
                    FN_AND: begin d.op = ALU_AND; d.we_regfile = 1'b1; end
                    FN_OR:  begin d.op = ALU_OR;  d.we_regfile = 1'b1; end
                    FN_NOR: begin d.op = ALU_NOR; d.we_regfile = 1'b1; end
                    FN_SLT: begin d.op = ALU_SLT; d.we_regfile = 1'b1; end
                    FN_JR:  begin d.jump_type = JT_JR; end
                    // Unsupported function: stays a NOP with enables cleared.
                    default: begin d.op = ALU_NOP; end
                endcase
            end
            OPC_ADDI: begin
                d.op         = ALU_ADD;
                d.we_regfile = 1'b1;
                d.rdst_id    = instr[20:16];
            end
            OPC_SLTI: begin
                d.op         = ALU_SLT;
                d.we_regfile = 1'b1;
                d.rdst_id    = instr[20:16];
            end
            OPC_LW: begin
                d.op         = ALU_ADD;
                d.we_regfile = 1'b1;
                d.wbsel      = WB_MEM;
                d.rdst_id    = instr[20:16];
                d.is_load    = 1'b1;
            end
            OPC_LB: begin
                d.op         = ALU_ADD;
                d.we_regfile = 1'b1;
                d.wbsel      = WB_MEM;
                d.mem_byte   = 1'b1;
                d.rdst_id    = instr[20:16];
                d.is_load    = 1'b1;
            end
            OPC_SW: begin
                d.op      = ALU_ADD;
                d.we_dmem = 1'b1;
                d.use_rt  = 1'b1;
            end
            OPC_BEQ: begin
                d.op        = ALU_SUB;
                d.ssel      = 1'b1;
                d.jump_type = JT_BEQ;
                d.use_rt    = 1'b1;
            end
            OPC_BGTZ: begin
                d.jump_type = JT_BGTZ;
            end
            OPC_J: begin
                d.jump_type = JT_J;
                d.use_rs    = 1'b0;
            end
            OPC_JAL: begin
                d.jump_type  = JT_JAL;
                d.we_regfile = 1'b1;
                d.wbsel      = WB_PC4;
                d.rdst_id    = 5'd31;
                d.use_rs     = 1'b0;
            end
            // Unknown opcode: NOP, all enables 0.
            default: begin d.op = ALU_NOP; end
        endcase
        return d;
    endfunction

    dec_t                dec_s;
    logic [DWIDTH-1:0]   imm_s;
    logic                advance_s;
    logic                src_hit_s;
    logic                hazard_s;
    logic                ld_set_s;
    logic                cnt_sat_s;

    logic                ld_pend_r;
    logic [4:0]          ld_rd_r;
    logic                is_load_r;

    // Decode, handshake and load-use hazard detection.
    always_comb begin
        dec_s     = decode_fn(in_instr[31:0]);
        imm_s     = {{(DWIDTH-16){in_instr[15]}}, in_instr[15:0]};
        advance_s = !out_valid || out_ready;
        src_hit_s = (dec_s.use_rs && (in_instr[25:21] == ld_rd_r)) ||
                    (dec_s.use_rt && (in_instr[20:16] == ld_rd_r));
        hazard_s  = (LOAD_USE_STALL != 0) && ld_pend_r && in_valid && src_hit_s;
        in_ready  = !flush && !hazard_s && advance_s;
        // A load leaving toward EX arms the interlock for exactly one cycle;
        // loads into $zero never produce a dependency, and flush disarms it.
        ld_set_s  = !flush && out_valid && out_ready && is_load_r && (rdst_id != 5'd0);
        cnt_sat_s = (stall_cnt == {CNT_WIDTH{1'b1}});
    end

    // ID/EX register, load tracking and stall counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            out_pc     <= {DWIDTH{1'b0}};
            op         <= 4'b0000;
            ssel       <= 1'b0;
            wbsel      <= 2'b00;
            we_regfile <= 1'b0;
            we_dmem    <= 1'b0;
            mem_byte   <= 1'b0;
            jump_type  <= 3'b000;
            jump_addr  <= 26'd0;
            imm        <= {DWIDTH{1'b0}};
            rs1_id     <= 5'd0;
            rs2_id     <= 5'd0;
            rdst_id    <= 5'd0;
            is_load_r  <= 1'b0;
            ld_pend_r  <= 1'b0;
            ld_rd_r    <= 5'd0;
            stall_cnt  <= {CNT_WIDTH{1'b0}};
        end else begin
            ld_pend_r <= ld_set_s;
            ld_rd_r   <= rdst_id;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (advance_s) begin
                if (hazard_s) begin
                    // Bubble: fields hold, only out_valid drops.
                    out_valid <= 1'b0;
                    if (!cnt_sat_s) begin
                        stall_cnt <= stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end else if (in_valid) begin
                    out_valid  <= 1'b1;
                    out_pc     <= in_pc;
                    op         <= dec_s.op;
                    ssel       <= dec_s.ssel;
                    wbsel      <= dec_s.wbsel;
                    we_regfile <= dec_s.we_regfile;
                    we_dmem    <= dec_s.we_dmem;
                    mem_byte   <= dec_s.mem_byte;
                    jump_type  <= dec_s.jump_type;
                    jump_addr  <= in_instr[25:0];
                    imm        <= imm_s;
                    rs1_id     <= in_instr[25:21];
                    rs2_id     <= in_instr[20:16];
                    rdst_id    <= dec_s.rdst_id;
                    is_load_r  <= dec_s.is_load;
                end else begin
                    out_valid <= 1'b0;
                end
            end else begin
                // Back-pressure: everything holds.
                out_valid <= out_valid;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_decode_stage_pipe
//
// Drives two decode stages from the same stimulus: instance a with the
// load-use interlock enabled, instance b with it disabled. Both use a 3-bit
// stall counter so saturation is reachable quickly. A behavioural reference
// model (instruction table plus per-instance pipeline state) predicts
// in_ready, out_valid, every decode field and stall_cnt each cycle.
// -----------------------------------------------------------------------------
module tb_decode_stage_pipe;

    localparam int DW = 32;
    localparam int CW = 3;

    localparam logic [31:0] I_ADDI  = 32'h20080005; // addi $t0,$zero,5
    localparam logic [31:0] I_ADD   = 32'h01084820; // add  $t1,$t0,$t0
    localparam logic [31:0] I_LW    = 32'h8C080000; // lw   $t0,0($zero)
    localparam logic [31:0] I_LBZ   = 32'h80000000; // lb   $zero,0($zero)
    localparam logic [31:0] I_ADDZ  = 32'h00004820; // add  $t1,$zero,$zero
    localparam logic [31:0] I_J     = 32'h08000100; // j    0x100
    localparam logic [31:0] I_BGTZ  = 32'h1D000003; // bgtz $t0,3
    localparam logic [31:0] I_JAL   = 32'h0C000100; // jal  0x100

    typedef struct packed {
        logic [3:0]  op;
        logic        ssel;
        logic [1:0]  wbsel;
        logic        we_rf;
        logic        we_dm;
        logic        mb;
        logic [2:0]  jt;
        logic [25:0] ja;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
    } fields_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, flush, in_valid, out_ready;
    logic [DW-1:0] in_instr, in_pc;

    logic          in_ready_a, out_valid_a, ssel_a, we_regfile_a, we_dmem_a, mem_byte_a;
    logic [DW-1:0] out_pc_a, imm_a;
    logic [3:0]    op_a;
    logic [1:0]    wbsel_a;
    logic [2:0]    jump_type_a;
    logic [25:0]   jump_addr_a;
    logic [4:0]    rs1_id_a, rs2_id_a, rdst_id_a;
    logic [CW-1:0] stall_cnt_a;

    logic          in_ready_b, out_valid_b, ssel_b, we_regfile_b, we_dmem_b, mem_byte_b;
    logic [DW-1:0] out_pc_b, imm_b;
    logic [3:0]    op_b;
    logic [1:0]    wbsel_b;
    logic [2:0]    jump_type_b;
    logic [25:0]   jump_addr_b;
    logic [4:0]    rs1_id_b, rs2_id_b, rdst_id_b;
    logic [CW-1:0] stall_cnt_b;

    fields_t act_a, act_b;
    assign act_a = {op_a, ssel_a, wbsel_a, we_regfile_a, we_dmem_a, mem_byte_a, jump_type_a,
                    jump_addr_a, imm_a, rs1_id_a, rs2_id_a, rdst_id_a, out_pc_a};
    assign act_b = {op_b, ssel_b, wbsel_b, we_regfile_b, we_dmem_b, mem_byte_b, jump_type_b,
                    jump_addr_b, imm_b, rs1_id_b, rs2_id_b, rdst_id_b, out_pc_b};

    decode_stage_pipe #(.DWIDTH(DW), .CNT_WIDTH(CW), .LOAD_USE_STALL(1)) dut_a (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a),
        .op(op_a), .ssel(ssel_a), .wbsel(wbsel_a), .we_regfile(we_regfile_a),
        .we_dmem(we_dmem_a), .mem_byte(mem_byte_a), .jump_type(jump_type_a),
        .jump_addr(jump_addr_a), .imm(imm_a), .rs1_id(rs1_id_a), .rs2_id(rs2_id_a),
        .rdst_id(rdst_id_a), .stall_cnt(stall_cnt_a)
    );

    decode_stage_pipe #(.DWIDTH(DW), .CNT_WIDTH(CW), .LOAD_USE_STALL(0)) dut_b (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b),
        .op(op_b), .ssel(ssel_b), .wbsel(wbsel_b), .we_regfile(we_regfile_b),
        .we_dmem(we_dmem_b), .mem_byte(mem_byte_b), .jump_type(jump_type_b),
        .jump_addr(jump_addr_b), .imm(imm_b), .rs1_id(rs1_id_b), .rs2_id(rs2_id_b),
        .rdst_id(rdst_id_b), .stall_cnt(stall_cnt_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state, index 0 = instance a (interlock on), 1 = instance b.
    logic          m_valid [2];
    fields_t       m_f     [2];
    logic          m_lp    [2];
    logic [4:0]    m_lrd   [2];
    logic          m_load  [2];
    logic [CW-1:0] m_cnt   [2];

    logic rdy_a, rdy_b;
    fields_t snap;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction table: what each mnemonic puts in the ID/EX register.
    function automatic fields_t ref_fields(input logic [31:0] i, input logic [31:0] pc);
        fields_t f;
        f     = '0;
        f.op  = 4'b1111;
        f.ja  = i[25:0];
        f.imm = {{16{i[15]}}, i[15:0]};
        f.rs1 = i[25:21];
        f.rs2 = i[20:16];
        f.pc  = pc;
        case (i[31:26])
            6'h00: begin
                f.ssel = 1'b1;
                f.rd   = i[15:11];
                case (i[5:0])
                    6'h20: begin f.op = 4'b0010; f.we_rf = 1'b1; end
                    6'h22: begin f.op = 4'b0110; f.we_rf = 1'b1; end
                    6'h24: begin f.op = 4'b0000; f.we_rf = 1'b1; end
                    6'h25: begin f.op = 4'b0001; f.we_rf = 1'b1; end
                    6'h27: begin f.op = 4'b1100; f.we_rf = 1'b1; end
                    6'h2A: begin f.op = 4'b0111; f.we_rf = 1'b1; end
                    6'h08: f.jt = 3'b011;
                    default: f.op = 4'b1111;
                endcase
            end
            6'h08: begin f.op = 4'b0010; f.we_rf = 1'b1; f.rd = i[20:16]; end
            6'h0A: begin f.op = 4'b0111; f.we_rf = 1'b1; f.rd = i[20:16]; end
            6'h23: begin f.op = 4'b0010; f.we_rf = 1'b1; f.wbsel = 2'd1; f.rd = i[20:16]; end
            6'h20: begin f.op = 4'b0010; f.we_rf = 1'b1; f.wbsel = 2'd1; f.mb = 1'b1; f.rd = i[20:16]; end
            6'h2B: begin f.op = 4'b0010; f.we_dm = 1'b1; end
            6'h04: begin f.op = 4'b0110; f.ssel = 1'b1; f.jt = 3'b001; end
            6'h07: f.jt = 3'b101;
            6'h02: f.jt = 3'b100;
            6'h03: begin f.jt = 3'b010; f.we_rf = 1'b1; f.wbsel = 2'd2; f.rd = 5'd31; end
            default: f.op = 4'b1111;
        endcase
        return f;
    endfunction

    function automatic logic is_load(input logic [31:0] i);
        return (i[31:26] == 6'h23) || (i[31:26] == 6'h20);
    endfunction

    // Does instruction i read register r as a source operand?
    function automatic logic reads_reg(input logic [31:0] i, input logic [4:0] r);
        case (i[31:26])
            6'h02, 6'h03:        return 1'b0;
            6'h00, 6'h04, 6'h2B: return (i[25:21] == r) || (i[20:16] == r);
            default:             return i[25:21] == r;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] im;
        int          k;
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        im = 16'($urandom);
        k  = $urandom_range(0, 16);
        case (k)
            0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            1:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
            2:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
            3:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4:  return {6'h00, rs, rt, rd, 5'd0, 6'h27};
            5:  return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            6:  return {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08};
            7:  return {6'h08, rs, rt, im};
            8:  return {6'h0A, rs, rt, im};
            9:  return {6'h23, rs, rt, im};
            10: return {6'h20, rs, rt, im};
            11: return {6'h2B, rs, rt, im};
            12: return {6'h04, rs, rt, im};
            13: return {6'h07, rs, 5'd0, im};
            14: return {6'h02, 26'($urandom)};
            15: return {6'h03, 26'($urandom)};
            default: return {6'h3F, rs, rt, im};
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_f[k]     = '0;
            m_lp[k]    = 1'b0;
            m_lrd[k]   = 5'd0;
            m_load[k]  = 1'b0;
            m_cnt[k]   = 3'd0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid_a"}, 128'(out_valid_a), 128'(m_valid[0]));
        chk({tag, ".fields_a"}, 128'(act_a), 128'(m_f[0]));
        chk({tag, ".stall_a"}, 128'(stall_cnt_a), 128'(m_cnt[0]));
        chk({tag, ".valid_b"}, 128'(out_valid_b), 128'(m_valid[1]));
        chk({tag, ".fields_b"}, 128'(act_b), 128'(m_f[1]));
        chk({tag, ".stall_b"}, 128'(stall_cnt_b), 128'(m_cnt[1]));
    endtask

    // One clock: drive inputs, check in_ready, advance the model, check outputs.
    task automatic step(input string tag, input logic f, input logic iv,
                        input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
        logic haz, rdy, nlp;
        logic [4:0] nlrd;
        flush = f; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
        #1;
        rdy_a = in_ready_a;
        rdy_b = in_ready_b;
        for (int k = 0; k < 2; k++) begin
            haz = (k == 0) && m_lp[k] && iv && reads_reg(ins, m_lrd[k]);
            rdy = !f && !haz && (!m_valid[k] || ordy);
            if (k == 0) chk({tag, ".in_ready_a"}, 128'(in_ready_a), 128'(rdy));
            else        chk({tag, ".in_ready_b"}, 128'(in_ready_b), 128'(rdy));
            nlp  = !f && m_valid[k] && ordy && m_load[k] && (m_f[k].rd != 5'd0);
            nlrd = m_f[k].rd;
            if (f) begin
                m_valid[k] = 1'b0;
            end else if (!m_valid[k] || ordy) begin
                if (haz) begin
                    m_valid[k] = 1'b0;
                    if (m_cnt[k] != 3'd7) m_cnt[k] = m_cnt[k] + 3'd1;
                end else if (iv) begin
                    m_f[k]     = ref_fields(ins, pc);
                    m_load[k]  = is_load(ins);
                    m_valid[k] = 1'b1;
                end else begin
                    m_valid[k] = 1'b0;
                end
            end
            m_lp[k]  = nlp;
            m_lrd[k] = nlrd;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        // Reset held two cycles with a valid instruction presented.
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h100; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outputs("reset");
        chk("reset.fields_zero", 128'(act_a), 128'(0));
        rstn = 1'b1;

        // Streaming addi then dependent add, no stall.
        step("addi", 1'b0, 1'b1, I_ADDI, 32'h100, 1'b1);
        chk("addi.valid", 128'(out_valid_a), 128'(1'b1));
        chk("addi.op", 128'(op_a), 128'(4'b0010));
        chk("addi.ssel", 128'(ssel_a), 128'(1'b0));
        chk("addi.imm", 128'(imm_a), 128'(32'd5));
        chk("addi.rd", 128'(rdst_id_a), 128'(5'd8));
        step("add", 1'b0, 1'b1, I_ADD, 32'h104, 1'b1);
        chk("add.rdy", 128'(rdy_a), 128'(1'b1));
        chk("add.op", 128'(op_a), 128'(4'b0010));
        chk("add.ssel", 128'(ssel_a), 128'(1'b1));
        chk("add.rd", 128'(rdst_id_a), 128'(5'd9));
        chk("add.nostall", 128'(stall_cnt_a), 128'(3'd0));

        // Load-use: lw leaves, then the consumer is presented.
        step("lu.lw", 1'b0, 1'b1, I_LW, 32'h108, 1'b1);
        step("lu.gap", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step("lu.bub", 1'b0, 1'b1, I_ADD, 32'h10C, 1'b1);
        chk("lu.bub_rdy_a", 128'(rdy_a), 128'(1'b0));
        chk("lu.bub_valid_a", 128'(out_valid_a), 128'(1'b0));
        chk("lu.nostall_rdy_b", 128'(rdy_b), 128'(1'b1));
        step("lu.add", 1'b0, 1'b1, I_ADD, 32'h10C, 1'b1);
        chk("lu.add_rdy_a", 128'(rdy_a), 128'(1'b1));
        chk("lu.cnt_a", 128'(stall_cnt_a), 128'(3'd1));
        chk("lu.cnt_b", 128'(stall_cnt_b), 128'(3'd0));

        // lb into $zero followed by a $zero user: no stall.
        step("z.lb", 1'b0, 1'b1, I_LBZ, 32'h110, 1'b1);
        step("z.gap", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step("z.add", 1'b0, 1'b1, I_ADDZ, 32'h114, 1'b1);
        chk("z.rdy", 128'(rdy_a), 128'(1'b1));

        // lw $t0 followed by j: j reads nothing, no stall.
        step("j.lw", 1'b0, 1'b1, I_LW, 32'h118, 1'b1);
        step("j.gap", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step("j.j", 1'b0, 1'b1, I_J, 32'h11C, 1'b1);
        chk("j.rdy", 128'(rdy_a), 128'(1'b1));
        chk("j.cnt", 128'(stall_cnt_a), 128'(3'd1));

        // bgtz and jal decode.
        step("bgtz", 1'b0, 1'b1, I_BGTZ, 32'h120, 1'b1);
        chk("bgtz.jt", 128'(jump_type_a), 128'(3'b101));
        chk("bgtz.we", 128'(we_regfile_a), 128'(1'b0));
        chk("bgtz.imm", 128'(imm_a), 128'(32'd3));
        step("jal", 1'b0, 1'b1, I_JAL, 32'h124, 1'b1);
        chk("jal.jt", 128'(jump_type_a), 128'(3'b010));
        chk("jal.wbsel", 128'(wbsel_a), 128'(2'd2));
        chk("jal.rd", 128'(rdst_id_a), 128'(5'd31));
        chk("jal.ja", 128'(jump_addr_a), 128'(26'h100));

        // Back-pressure for three cycles: held jal stays put.
        snap = m_f[0];
        for (int c = 0; c < 3; c++) begin
            step("bp", 1'b0, 1'b1, I_ADDI, 32'h128, 1'b0);
            chk("bp.rdy", 128'(rdy_a), 128'(1'b0));
            chk("bp.valid", 128'(out_valid_a), 128'(1'b1));
            chk("bp.hold", 128'(act_a), 128'(snap));
        end
        // Flush: output drops, input not consumed.
        step("flush", 1'b1, 1'b1, I_ADDI, 32'h128, 1'b0);
        chk("flush.rdy", 128'(rdy_a), 128'(1'b0));
        chk("flush.valid", 128'(out_valid_a), 128'(1'b0));
        step("post_flush", 1'b0, 1'b1, I_ADDI, 32'h128, 1'b1);
        chk("post_flush.pc", 128'(out_pc_a), 128'(32'h128));

        // Drive the stall counter to all-ones and beyond.
        for (int r = 0; r < 8; r++) begin
            step("sat.lw", 1'b0, 1'b1, I_LW, 32'h200, 1'b1);
            step("sat.gap", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            step("sat.bub", 1'b0, 1'b1, I_ADD, 32'h204, 1'b1);
            chk("sat.bub_rdy", 128'(rdy_a), 128'(1'b0));
            step("sat.add", 1'b0, 1'b1, I_ADD, 32'h204, 1'b1);
        end
        chk("sat.cnt", 128'(stall_cnt_a), 128'(3'd7));

        // Randomised traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            step("rand", ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0),
                 rand_instr(), $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
